flappy_game_ctrl: RTL

- Top-level game sequencer for the flappy dot datapath.
- Gates dot motion, clears the score counter between rounds, and detects a round end from the collision flag.
- Latches the final score and tracks a session high score.
- Runs on the dot frame clock; sits between the user buttons and the dot, column and score logic.

---
 rtl/flappy_game_ctrl_if.sv | 38 +++
 rtl/flappy_game_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the flappy game sequencer and its surroundings.
// Carries the user buttons, the collision flag and live score into the
// sequencer, and the motion gate, score clear, state and score registers out.
//   start, pause       : button levels (edge-detected inside the sequencer)
//   dot_collided       : collision flag from the dot datapath
//   score              : live score from the score counter
//   run_en             : dot/column motion enable
//   score_clear        : score counter clear
//   game_state         : 00 IDLE, 01 PLAY, 10 PAUSE, 11 DEAD
//   last_score         : score latched at the most recent collision
//   high_score         : session maximum of last_score
//   new_record         : one-cycle pulse when high_score updates
interface flappy_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               pause;
  logic               dot_collided;
  logic [SCORE_W-1:0] score;
  logic               run_en;
  logic               score_clear;
  logic [1:0]         game_state;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] high_score;
  logic               new_record;

  // Drives the sequencer inputs (buttons / datapath side).
  modport master (
    output start, pause, dot_collided, score,
    input  run_en, score_clear, game_state, last_score, high_score, new_record
  );

  // The sequencer itself.
  modport slave (
    input  start, pause, dot_collided, score,
    output run_en, score_clear, game_state, last_score, high_score, new_record
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Top-level game sequencer for the flappy dot datapath.
// Gates dot motion, clears the score counter between rounds, ends a round on
// collision, latches the final score and keeps a session high score.
// Ports:
//   dot_clk : frame clock, all state updates on its rising edge
//   resetn  : synchronous active-low reset
//   bus     : flappy_game_ctrl_if.slave (buttons, collision, score, outputs)
module flappy_game_ctrl #(
  parameter int DEAD_CYCLES = 120,
  parameter int SCORE_W     = 8
) (
  input  logic                  dot_clk,
  input  logic                  resetn,
  flappy_game_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_DEAD  = 2'b11
  } state_t;

  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [SCORE_W-1:0] last_q, last_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               rec_q, rec_d;
  logic               run_en_q;
  logic               clr_q;
  logic               start_q, pause_q;
  logic               start_rise, pause_rise;

  assign start_rise = bus.start & ~start_q;
  assign pause_rise = bus.pause & ~pause_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    high_d  = high_q;
    rec_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Collision has priority over a simultaneous pause press.
        if (bus.dot_collided) begin
          state_d = S_DEAD;
          last_d  = bus.score;
          cnt_d   = DEAD_LOAD;
          if (bus.score > high_q) begin
            high_d = bus.score;
            rec_d  = 1'b1;
          end
        end else if (pause_rise) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        // Abandoning the round beats resuming it.
        if (start_rise)      state_d = S_IDLE;
        else if (pause_rise) state_d = S_PLAY;
      end
      S_DEAD: begin
        // Counter loaded with DEAD_CYCLES-1, so residency counts down to 0.
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dot_clk) begin
    // Button history tracks the level even during reset, so a button held
    // through reset release is seen as already high and yields no edge.
    start_q <= bus.start;
    pause_q <= bus.pause;
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      last_q   <= '0;
      high_q   <= '0;
      rec_q    <= 1'b0;
      run_en_q <= 1'b0;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      high_q   <= high_d;
      rec_q    <= rec_d;
      run_en_q <= (state_d == S_PLAY);
      clr_q    <= (state_d == S_IDLE);
    end
  end

  assign bus.run_en      = run_en_q;
  assign bus.score_clear = clr_q;
  assign bus.game_state  = state_q;
  assign bus.last_score  = last_q;
  assign bus.high_score  = high_q;
  assign bus.new_record  = rec_q;

endmodule
